// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the instruction ROM and
// registers the fetched word into the IF/ID pipeline register. Handles
// stalls, ID-stage branch redirects (including ones arriving during a stall),
// exception flushes and misaligned fetch detection.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        id_adel_o
);

  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] id_pc_d, id_inst_d;
  logic        id_valid_d, id_adel_d;
  logic        stall_eff;
  logic        misaligned;

  // A held ID register implies IF must hold too.
  assign stall_eff  = stall_if | stall_id;
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign rom_addr_o = pc_q;

  // Next-PC selection and pending-redirect bookkeeping; nothing moves until
  // the ROM has been enabled.
  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (rom_ce_o) begin
      if (flush) begin
        pc_d         = new_pc;
        pend_valid_d = 1'b0;
      end else if (stall_eff) begin
        if (branch_flag_i) begin
          pend_valid_d  = 1'b1;
          pend_target_d = branch_target_i;
        end
      end else if (branch_flag_i) begin
        pc_d         = branch_target_i;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        pc_d         = pend_target_q;
        pend_valid_d = 1'b0;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // IF/ID register next value: flush clears, stall_id holds, an IF stall or
  // a disabled ROM inserts a bubble, otherwise capture the fetched word.
  always_comb begin
    id_pc_d    = id_pc_o;
    id_inst_d  = id_inst_o;
    id_valid_d = id_valid_o;
    id_adel_d  = id_adel_o;
    if (flush || (!stall_id && (stall_eff || !rom_ce_o))) begin
      id_pc_d    = 32'h0;
      id_inst_d  = 32'h0;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
    end else if (!stall_id) begin
      id_pc_d    = pc_q;
      id_inst_d  = misaligned ? 32'h0 : rom_inst_i;
      id_valid_d = 1'b1;
      id_adel_d  = misaligned;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_ce_o      <= 1'b0;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      id_pc_o       <= 32'h0;
      id_inst_o     <= 32'h0;
      id_valid_o    <= 1'b0;
      id_adel_o     <= 1'b0;
    end else begin
      rom_ce_o      <= 1'b1;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      id_pc_o       <= id_pc_d;
      id_inst_o     <= id_inst_d;
      id_valid_o    <= id_valid_d;
      id_adel_o     <= id_adel_d;
    end
  end

endmodule
